// File: rtl/conv_mac_seq.sv
// Multi-channel sequential conv MAC: one shared activation per cycle times N_CH weights over TAPS taps,
// then round-half-up, shift, saturate. Define CONV_MAC_RELU_EN to zero negative results before saturation.
module conv_mac_seq #(
   parameter int N_CH  = 4,
   parameter int A_W   = 13,
   parameter int W_W   = 8,
   parameter int ACC_W = 28,
   parameter int TAPS  = 9,
   parameter int SHIFT = 8,
   parameter int OUT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [A_W-1:0]    act,
   input  logic [N_CH*W_W-1:0]      wgt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_CH*OUT_W-1:0]    out_data,
   output logic [N_CH-1:0]          sat,
   output logic                     busy
);

   localparam int P_W     = A_W + W_W;
   localparam int CNT_W   = $clog2(TAPS + 1);
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [CNT_W-1:0]    LAST_TAP = CNT_W'(TAPS - 1);
   localparam logic signed [ACC_W:0] RND    = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
   localparam logic signed [ACC_W:0] MAX_V  = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W:0] MIN_V  = ~MAX_V;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        tap_cnt;
   logic signed [P_W-1:0]   prod [N_CH];
   logic                    p_valid;
   logic signed [ACC_W-1:0] acc [N_CH];
   logic signed [ACC_W:0]   shr [N_CH];
   logic [OUT_W-1:0]        res_nxt [N_CH];
   logic [N_CH-1:0]         sat_nxt;
   logic                    tap_accept, last_tap, clear, load_out;

   assign in_ready   = (state == ACCUM);
   assign out_valid  = (state == OUT);
   assign busy       = (state != IDLE);
   assign tap_accept = in_valid && in_ready;
   assign last_tap   = tap_accept && (tap_cnt == LAST_TAP);
   assign clear      = (state == IDLE) && start;
   // DRAIN holds until the last product has been folded into acc.
   assign load_out   = (state == DRAIN) && !p_valid;

   // NOTE: state and datapath registers use non-blocking assignments only; comb blocks use blocking.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start)     state_nxt = ACCUM;
         ACCUM: if (last_tap)  state_nxt = DRAIN;
         DRAIN: if (load_out)  state_nxt = OUT;
         OUT:   if (out_ready) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         shr[c]     = ((ACC_W+1)'(acc[c]) + RND) >>> SHIFT;
         res_nxt[c] = '0;
         sat_nxt[c] = 1'b0;
`ifdef CONV_MAC_RELU_EN
         if (shr[c] < 0) shr[c] = '0;
`endif
         if (shr[c] > MAX_V) begin
            res_nxt[c] = MAX_V[OUT_W-1:0];
            sat_nxt[c] = 1'b1;
         end else if (shr[c] < MIN_V) begin
            res_nxt[c] = MIN_V[OUT_W-1:0];
            sat_nxt[c] = 1'b1;
         end else begin
            res_nxt[c] = shr[c][OUT_W-1:0];
         end
      end
   end

   // NOTE: the small per-channel arrays are reset so an aborted job leaves no residue.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         tap_cnt  <= '0;
         p_valid  <= 1'b0;
         out_data <= '0;
         sat      <= '0;
         for (int c = 0; c < N_CH; c++) begin
            prod[c] <= '0;
            acc[c]  <= '0;
         end
      end else begin
         p_valid <= tap_accept;
         if (clear)           tap_cnt <= '0;
         else if (tap_accept) tap_cnt <= tap_cnt + 1'b1;
         for (int c = 0; c < N_CH; c++) begin
            if (tap_accept) prod[c] <= act * $signed(wgt[c*W_W +: W_W]);
            if (clear)        acc[c] <= '0;
            else if (p_valid) acc[c] <= acc[c] + ACC_W'(prod[c]);
            if (load_out) begin
               out_data[c*OUT_W +: OUT_W] <= res_nxt[c];
               sat[c]                     <= sat_nxt[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed self-checking bench for conv_mac_seq: default instance plus a SHIFT=0 instance on shared inputs.
module tb_conv_mac_seq;

   localparam int N_CH = 4, A_W = 13, W_W = 8, OUT_W = 16, TAPS = 9;

   logic                   clk_i = 1'b0;
   logic                   rst, start, in_valid, out_ready;
   logic signed [A_W-1:0]  act;
   logic [N_CH*W_W-1:0]    wgt;
   logic                   in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
   logic [N_CH*OUT_W-1:0]  out_data_a, out_data_b;
   logic [N_CH-1:0]        sat_a, sat_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   conv_mac_seq dut_a (
      .clk_i(clk_i), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
      .act(act), .wgt(wgt), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .sat(sat_a), .busy(busy_a)
   );

   conv_mac_seq #(.SHIFT(0)) dut_b (
      .clk_i(clk_i), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
      .act(act), .wgt(wgt), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .sat(sat_b), .busy(busy_b)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one job of TAPS taps (first tap a_first, rest a_rest) and checks latency on dut_a.
   // Returns at the negedge after the output-load edge; result is not yet consumed.
   task automatic run_job(input logic signed [A_W-1:0] a_first, input logic signed [A_W-1:0] a_rest,
                          input logic [N_CH*W_W-1:0] w, input bit gaps);
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      check("accum_in_ready", in_ready_a, 1);
      for (int i = 0; i < TAPS; i++) begin
         if (gaps && i > 0) begin
            in_valid = 1'b0;
            @(negedge clk_i);
         end
         in_valid = 1'b1;
         act      = (i == 0) ? a_first : a_rest;
         wgt      = w;
         @(negedge clk_i);
      end
      in_valid = 1'b0;
      // Last tap accepted on the previous edge (product register).
      check("lat_after_accept_valid", out_valid_a, 0);
      check("lat_in_ready_dropped", in_ready_a, 0);
      @(negedge clk_i);
      check("lat_after_accum_valid", out_valid_a, 0);
      @(negedge clk_i);
      check("lat_after_load_valid", out_valid_a, 1);
      for (int k = 0; k < 20 && !out_valid_a; k++) @(negedge clk_i);
   endtask

   task automatic check_result(input string tag, input bit use_b, input int exp [N_CH],
                               input logic [N_CH-1:0] exp_sat);
      logic [N_CH*OUT_W-1:0] d;
      d = use_b ? out_data_b : out_data_a;
      for (int c = 0; c < N_CH; c++)
         check($sformatf("%s_ch%0d", tag, c), longint'($signed(d[c*OUT_W +: OUT_W])), longint'(exp[c]));
      check({tag, "_sat"}, use_b ? sat_b : sat_a, exp_sat);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk_i);
      out_ready = 1'b0;
      check("after_handshake_valid", out_valid_a, 0);
      check("after_handshake_busy", busy_a, 0);
   endtask

   int exp_main [N_CH];
   int exp_one  [N_CH] = '{1, 1, 1, 1};
   int exp_zero [N_CH] = '{0, 0, 0, 0};
   int exp_pos  [N_CH] = '{32767, 32767, 32767, 32767};
   int exp_neg  [N_CH];
   logic [N_CH-1:0] exp_neg_sat;
   logic [N_CH*OUT_W-1:0] held;

   initial begin
`ifdef CONV_MAC_RELU_EN
      exp_main    = '{9, 0, 1143, 0};
      exp_neg     = '{0, 0, 0, 0};
      exp_neg_sat = 4'b0000;
`else
      exp_main    = '{9, -9, 1143, -1152};
      exp_neg     = '{-32768, -32768, -32768, -32768};
      exp_neg_sat = 4'b1111;
`endif
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; act = '0; wgt = '0;
      repeat (2) @(negedge clk_i);
      check("rst_busy", busy_a, 0);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_in_ready", in_ready_a, 0);
      check("rst_out_data", out_data_a, 0);
      check("rst_sat", sat_a, 0);
      rst = 1'b0;
      @(negedge clk_i);
      check("idle_in_ready", in_ready_a, 0);

      // Mixed-sign weights, act=256
      run_job(13'sd256, 13'sd256, 32'h807FFF01, 1'b0);
      check_result("main", 1'b0, exp_main, 4'b0000);
      consume();

      // Round half up: +0.5 -> 1, -0.5 -> 0
      run_job(13'sd128, 13'sd0, 32'h01010101, 1'b0);
      check_result("rnd_pos", 1'b0, exp_one, 4'b0000);
      consume();
      run_job(-13'sd128, 13'sd0, 32'h01010101, 1'b0);
      check_result("rnd_neg", 1'b0, exp_zero, 4'b0000);
      consume();

      // SHIFT=0 saturation
      run_job(13'sd4095, 13'sd4095, 32'h7F7F7F7F, 1'b0);
      check_result("sat_pos", 1'b1, exp_pos, 4'b1111);
      consume();
      run_job(-13'sd4096, -13'sd4096, 32'h7F7F7F7F, 1'b0);
      check_result("sat_neg", 1'b1, exp_neg, exp_neg_sat);
      consume();

      // Input gaps, output backpressure, start ignored in OUT
      run_job(13'sd256, 13'sd256, 32'h807FFF01, 1'b1);
      check_result("gap", 1'b0, exp_main, 4'b0000);
      held = out_data_a;
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         @(negedge clk_i);
         check("bp_valid_held", out_valid_a, 1);
         check("bp_data_stable", out_data_a, held);
      end
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      out_ready = 1'b0;
      check("hs_start_ignored_busy", busy_a, 0);
      check("hs_in_ready", in_ready_a, 0);
      @(negedge clk_i);
      check("hs_still_idle", busy_a, 0);
      check_result("bp_after", 1'b0, exp_main, 4'b0000);

      // Async reset mid-accumulation, then clean rerun
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; act = 13'sd1000; wgt = 32'h7F7F7F7F;
         @(negedge clk_i);
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy_a, 0);
      check("arst_out_valid", out_valid_a, 0);
      check("arst_in_ready", in_ready_a, 0);
      @(negedge clk_i);
      rst = 1'b0;
      @(negedge clk_i);
      run_job(13'sd256, 13'sd256, 32'h807FFF01, 1'b0);
      check_result("post_rst", 1'b0, exp_main, 4'b0000);
      consume();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
